// File: rtl/asrv32_pkg.sv
// Shared ASRV32 register-file definitions: widths, legal register counts and
// the clear-sequencer state encoding.
package asrv32_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int RV32I_NREGS  = 32;
  localparam int RV32E_NREGS  = 16;

  typedef enum logic {RF_CLEAR, RF_RUN} rf_state_t;
endpackage

// File: rtl/asrv32_regfile_clr.sv
// Post-reset clear sequencer: walks x1..x(NREGS-1) writing zero, then enters
// RUN. busy is high for the whole CLEAR phase.
module asrv32_regfile_clr
  import asrv32_pkg::*;
#(
  parameter int NREGS = RV32I_NREGS
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  output logic                  clr_we,
  output logic [REG_ADDR_W-1:0] clr_addr
);
  rf_state_t             state_reg;
  logic [REG_ADDR_W-1:0] cnt_reg;

  // The counter may wrap after the last register; it is ignored in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RF_CLEAR;
      cnt_reg   <= REG_ADDR_W'(1);
    end else if (state_reg == RF_CLEAR) begin
      cnt_reg <= cnt_reg + REG_ADDR_W'(1);
      if (32'(cnt_reg) == NREGS - 1) state_reg <= RF_RUN;
    end
  end

  assign busy     = (state_reg == RF_CLEAR);
  assign clr_we   = busy && !rst;
  assign clr_addr = cnt_reg;
endmodule

// File: rtl/asrv32_regfile_mp.sv
// Parametrised multi-port ASRV32 integer register file with registered reads
// and a post-reset clear sequencer. Define ASRV32_REGFILE_BYPASS_EN to forward
// same-edge write data to colliding read ports.
module asrv32_regfile_mp
  import asrv32_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = RV32I_NREGS,
  parameter int NRD   = 2
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_ce_rd,
  input  logic [NRD*REG_ADDR_W-1:0] i_rs_addr,
  input  logic                      i_ce_wr,
  input  logic [REG_ADDR_W-1:0]     i_rd_addr,
  input  logic [XLEN-1:0]           i_rd_data,
  output logic [NRD*XLEN-1:0]       o_rs_data,
  output logic [NRD-1:0]            o_rs_illegal,
  output logic                      o_busy
);
  localparam int AW = $clog2(NREGS);

  if (!(NREGS == RV32I_NREGS || NREGS == RV32E_NREGS)) begin : g_bad_nregs
    $error("asrv32_regfile_mp: NREGS must be 16 or 32");
  end
  if (NRD < 1 || NRD > 3) begin : g_bad_nrd
    $error("asrv32_regfile_mp: NRD must be 1..3");
  end

  logic                  clr_we;
  logic [REG_ADDR_W-1:0] clr_addr;

  asrv32_regfile_clr #(.NREGS(NREGS)) u_clr (
    .clk      (i_clk),
    .rst      (i_rst),
    .busy     (o_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  logic            user_we;
  logic            wr_en;
  logic [AW-1:0]   wr_idx;
  logic [XLEN-1:0] wr_data;

  assign user_we = !i_rst && !o_busy && i_ce_wr &&
                   (i_rd_addr != '0) && (32'(i_rd_addr) < NREGS);

  // The sequencer owns the write port for the whole CLEAR phase.
  always_comb begin
    wr_en   = clr_we || user_we;
    wr_idx  = o_busy ? clr_addr[AW-1:0] : i_rd_addr[AW-1:0];
    wr_data = o_busy ? '0 : i_rd_data;
  end

  // x0 has no storage.
  logic [XLEN-1:0] mem [1:NREGS-1];

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
    logic [REG_ADDR_W-1:0] addr;
    logic                  bypass_hit;
    logic [XLEN-1:0]       data_reg;
    logic                  illegal_reg;

    assign addr = i_rs_addr[gi*REG_ADDR_W +: REG_ADDR_W];
`ifdef ASRV32_REGFILE_BYPASS_EN
    assign bypass_hit = user_we && (i_rd_addr == addr);
`else
    assign bypass_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        data_reg    <= '0;
        illegal_reg <= 1'b0;
      end else if (i_ce_rd) begin
        if (o_busy || addr == '0) begin
          data_reg    <= '0;
          illegal_reg <= 1'b0;
        end else if (32'(addr) >= NREGS) begin
          data_reg    <= '0;
          illegal_reg <= 1'b1;
        end else begin
          data_reg    <= bypass_hit ? i_rd_data : mem[addr[AW-1:0]];
          illegal_reg <= 1'b0;
        end
      end
    end

    assign o_rs_data[gi*XLEN +: XLEN] = data_reg;
    assign o_rs_illegal[gi]           = illegal_reg;
  end
endmodule

// File: tb/tb_asrv32_regfile_mp.sv
// Self-checking bench for asrv32_regfile_mp: an RV32I 3-port instance checked
// against an array model, plus an RV32E 2-port instance for range handling.
module tb_asrv32_regfile_mp;
  logic        clk = 1'b0;
  logic        rst;
  logic        ce_rd, ce_wr;
  logic [14:0] rs_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic [95:0] rs_data;
  logic [2:0]  rs_ill;
  logic        busy;

  logic        e_ce_rd, e_ce_wr;
  logic [9:0]  e_rs_addr;
  logic [4:0]  e_rd_addr;
  logic [31:0] e_rd_data;
  logic [63:0] e_rs_data;
  logic [1:0]  e_rs_ill;
  logic        e_busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] m [32];

  always #5 clk = ~clk;

  asrv32_regfile_mp #(.XLEN(32), .NREGS(32), .NRD(3)) dut (
    .i_clk(clk), .i_rst(rst), .i_ce_rd(ce_rd), .i_rs_addr(rs_addr),
    .i_ce_wr(ce_wr), .i_rd_addr(rd_addr), .i_rd_data(rd_data),
    .o_rs_data(rs_data), .o_rs_illegal(rs_ill), .o_busy(busy)
  );

  asrv32_regfile_mp #(.XLEN(32), .NREGS(16), .NRD(2)) dut_e (
    .i_clk(clk), .i_rst(rst), .i_ce_rd(e_ce_rd), .i_rs_addr(e_rs_addr),
    .i_ce_wr(e_ce_wr), .i_rd_addr(e_rd_addr), .i_rd_data(e_rd_data),
    .o_rs_data(e_rs_data), .o_rs_illegal(e_rs_ill), .o_busy(e_busy)
  );

  // Expected read value, evaluated before the edge (model holds old contents).
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic cwr,
                                         input logic [4:0] wa, input logic [31:0] wd);
    if (a == 5'd0) return 32'd0;
`ifdef ASRV32_REGFILE_BYPASS_EN
    if (cwr && wa == a) return wd;
`endif
    return m[a];
  endfunction

  // One RUN-phase transaction on the RV32I instance; updates the model.
  task automatic cycle(input logic crd, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2, input logic cwr, input logic [4:0] wa,
                       input logic [31:0] wd);
    ce_rd = crd; rs_addr = {a2, a1, a0};
    ce_wr = cwr; rd_addr = wa; rd_data = wd;
    @(negedge clk);
    if (cwr && wa != 5'd0) m[wa] = wd;
    ce_rd = 1'b0; ce_wr = 1'b0;
    $display("txn t=%0t rd=%0b a=%0d,%0d,%0d wr=%0b x%0d=%h -> %h %h %h ill=%b",
             $time, crd, a0, a1, a2, cwr, wa, wd,
             rs_data[31:0], rs_data[63:32], rs_data[95:64], rs_ill);
  endtask

  task automatic e_cycle(input logic crd, input logic [4:0] a0, input logic [4:0] a1,
                         input logic cwr, input logic [4:0] wa, input logic [31:0] wd);
    e_ce_rd = crd; e_rs_addr = {a1, a0};
    e_ce_wr = cwr; e_rd_addr = wa; e_rd_data = wd;
    @(negedge clk);
    e_ce_rd = 1'b0; e_ce_wr = 1'b0;
    $display("txn_e t=%0t rd=%0b a=%0d,%0d wr=%0b x%0d=%h -> %h %h ill=%b",
             $time, crd, a0, a1, cwr, wa, wd, e_rs_data[31:0], e_rs_data[63:32], e_rs_ill);
  endtask

  // Counts edges after reset release until busy is seen low (bounded).
  task automatic wait_run(input int base, output int n, output int en);
    n = -1; en = -1;
    for (int i = base + 1; i <= base + 40; i++) begin
      @(negedge clk);
      if (!busy && n < 0) n = i;
      if (!e_busy && en < 0) en = i;
      if (n >= 0 && en >= 0) break;
    end
    for (int r = 0; r < 32; r++) m[r] = 32'd0;
  endtask

  task automatic test_reset;
    int n, en;
    rst = 1'b1; ce_rd = 1'b1; rs_addr = {5'd31, 5'd2, 5'd1}; ce_wr = 1'b0;
    e_ce_rd = 1'b1; e_rs_addr = {5'd3, 5'd20}; e_ce_wr = 1'b0;
    rd_addr = '0; rd_data = '0; e_rd_addr = '0; e_rd_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rs_data !== 96'd0 || rs_ill !== 3'd0 || busy !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_state: data=%h ill=%b busy=%b, want 0/0/1", rs_data, rs_ill, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (rs_data !== 96'd0 || e_rs_ill !== 2'd0 || busy !== 1'b1 || e_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL first_edge: data=%h e_ill=%b busy=%b e_busy=%b, want 0/0/1/1",
               rs_data, e_rs_ill, busy, e_busy);
    end
    wait_run(1, n, en);
    ce_rd = 1'b0; e_ce_rd = 1'b0;
    n_cmp++;
    if (n != 31) begin n_bad++; $display("FAIL busy_len32: got %0d want 31", n); end
    n_cmp++;
    if (en != 15) begin n_bad++; $display("FAIL busy_len16: got %0d want 15", en); end
  endtask

  task automatic test_reset_clear;
    int n, en;
    for (int a = 1; a < 32; a++) cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'(a), 32'hFFFF_FFFF);
    cycle(1'b1, 5'd31, 5'd1, 5'd16, 1'b0, 5'd0, 32'd0);
    n_cmp++;
    if (rs_data !== {3{32'hFFFF_FFFF}}) begin
      n_bad++; $display("FAIL prefill: got %h want all ones", rs_data);
    end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    wait_run(0, n, en);
    n_cmp++;
    if (n != 31) begin n_bad++; $display("FAIL busy_len_clear: got %0d want 31", n); end
    for (int a = 1; a < 32; a += 3) begin
      logic [4:0] a0, a1, a2;
      a0 = 5'(a); a1 = 5'((a + 1) % 32); a2 = 5'((a + 2) % 32);
      cycle(1'b1, a0, a1, a2, 1'b0, 5'd0, 32'd0);
      n_cmp++;
      if (rs_data !== 96'd0) begin
        n_bad++; $display("FAIL clear_read x%0d..: got %h want 0", a, rs_data);
      end
    end
  endtask

  task automatic test_basic;
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd5, 32'hDEAD_BEEF);
    cycle(1'b1, 5'd5, 5'd0, 5'd5, 1'b0, 5'd0, 32'd0);
    n_cmp++;
    if (rs_data[31:0] !== 32'hDEAD_BEEF || rs_data[63:32] !== 32'd0) begin
      n_bad++; $display("FAIL basic_rw: got %h/%h want deadbeef/0", rs_data[31:0], rs_data[63:32]);
    end
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'h1234);
    cycle(1'b1, 5'd0, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0);
    n_cmp++;
    if (rs_data[31:0] !== 32'd0) begin
      n_bad++; $display("FAIL x0_write: got %h want 0", rs_data[31:0]);
    end
  endtask

  task automatic test_collision;
    logic [31:0] e;
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd7, 32'h1111_1111);
    e = exp_rd(5'd7, 1'b1, 5'd7, 32'hA5A5_A5A5);
    cycle(1'b1, 5'd7, 5'd0, 5'd7, 1'b1, 5'd7, 32'hA5A5_A5A5);
    n_cmp++;
    if (rs_data[31:0] !== e || rs_data[95:64] !== e || rs_data[63:32] !== 32'd0) begin
      n_bad++; $display("FAIL collision: got %h/%h/%h want %h/0/%h",
                        rs_data[31:0], rs_data[63:32], rs_data[95:64], e, e);
    end
    cycle(1'b1, 5'd7, 5'd7, 5'd7, 1'b0, 5'd0, 32'd0);
    n_cmp++;
    if (rs_data !== {3{32'hA5A5_A5A5}}) begin
      n_bad++; $display("FAIL after_collision: got %h want a5a5a5a5 x3", rs_data);
    end
  endtask

  task automatic test_hold;
    cycle(1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 5'd9, 32'h42);
    cycle(1'b1, 5'd9, 5'd9, 5'd9, 1'b0, 5'd0, 32'd0);
    n_cmp++;
    if (rs_data !== {3{32'h42}}) begin
      n_bad++; $display("FAIL multiport: got %h want 42 x3", rs_data);
    end
    cycle(1'b0, 5'd5, 5'd7, 5'd1, 1'b1, 5'd9, 32'h77);
    n_cmp++;
    if (rs_data !== {3{32'h42}} || rs_ill !== 3'd0) begin
      n_bad++; $display("FAIL hold: got %h ill=%b want 42 x3 ill=0", rs_data, rs_ill);
    end
  endtask

  task automatic test_random;
    logic [31:0] hold_q [3];
    logic [4:0]  a [3];
    logic        crd, cwr;
    logic [4:0]  wa;
    logic [31:0] wd;
    for (int k = 0; k < 3; k++) hold_q[k] = rs_data[k*32 +: 32];
    for (int i = 0; i < 200; i++) begin
      crd = 1'($urandom_range(0, 3) != 0);
      cwr = 1'($urandom_range(0, 1));
      wa  = 5'($urandom_range(0, 31));
      wd  = $urandom;
      for (int k = 0; k < 3; k++) begin
        a[k] = (i % 4 == 0) ? wa : 5'($urandom_range(0, 31));
        if (crd) hold_q[k] = exp_rd(a[k], cwr, wa, wd);
      end
      cycle(crd, a[0], a[1], a[2], cwr, wa, wd);
      for (int k = 0; k < 3; k++) begin
        n_cmp++;
        if (rs_data[k*32 +: 32] !== hold_q[k] || rs_ill[k] !== 1'b0) begin
          n_bad++;
          $display("FAIL random[%0d] port%0d: got %h ill=%b want %h ill=0",
                   i, k, rs_data[k*32 +: 32], rs_ill[k], hold_q[k]);
        end
      end
    end
  endtask

  task automatic test_rv32e;
    e_cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd15, 32'h77);
    e_cycle(1'b0, 5'd0, 5'd0, 1'b1, 5'd20, 32'h55);
    e_cycle(1'b1, 5'd20, 5'd15, 1'b0, 5'd0, 32'd0);
    n_cmp++;
    if (e_rs_data !== {32'h77, 32'd0} || e_rs_ill !== 2'b01) begin
      n_bad++; $display("FAIL rv32e_range: got %h ill=%b want 00000077_00000000 ill=01",
                        e_rs_data, e_rs_ill);
    end
    e_cycle(1'b1, 5'd15, 5'd20, 1'b1, 5'd20, 32'h66);
    n_cmp++;
    if (e_rs_data !== {32'd0, 32'h77} || e_rs_ill !== 2'b10) begin
      n_bad++; $display("FAIL rv32e_nobypass: got %h ill=%b want 00000000_00000077 ill=10",
                        e_rs_data, e_rs_ill);
    end
  endtask

  task automatic test_mid_clear;
    int n, en;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    ce_wr = 1'b1; rd_addr = 5'd3; rd_data = 32'h99;
    repeat (10) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_clear_busy: got %b want 1", busy); end
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    wait_run(0, n, en);
    ce_wr = 1'b0;
    n_cmp++;
    if (n != 31) begin n_bad++; $display("FAIL busy_len_restart: got %0d want 31", n); end
    cycle(1'b1, 5'd3, 5'd3, 5'd0, 1'b0, 5'd0, 32'd0);
    n_cmp++;
    if (rs_data !== 96'd0) begin
      n_bad++; $display("FAIL clear_wr_ignored: got %h want 0", rs_data);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_collision;
    test_hold;
    test_random;
    test_rv32e;
    test_reset_clear;
    test_mid_clear;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/asrv32_regfile_mp.md
# asrv32_regfile_mp

Parametrised multi-port integer register file for the ASRV32 core; replaces the fixed 2-read/1-write base register file in the decode/writeback path. Width, register count (RV32I 32 / RV32E 16) and read-port count are parameters. Read data is fully registered for block-RAM inference. A post-reset clear sequencer zeroes every register, and an optional write-to-read bypass covers same-edge collisions.

## Interface
- XLEN, 32, register width in bits.
- NREGS, 32, architectural register count; legal values 16 or 32.
- NRD, 2, read-port count; legal values 1 to 3.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_ce_rd  in  1  read enable; captures all read ports on the edge.
- i_rs_addr  in  NRD*5  read addresses; port k occupies bits [5k+4:5k].
- i_ce_wr  in  1  write enable.
- i_rd_addr  in  5  write address.
- i_rd_data  in  XLEN  write data.
- o_rs_data  out  NRD*XLEN  registered read data; port k occupies bits [XLEN*k+XLEN-1:XLEN*k].
- o_rs_illegal  out  NRD  registered flag per port; set when the captured address is >= NREGS.
- o_busy  out  1  high while the clear sequencer runs.

## Operation
- State machine has two states, CLEAR and RUN.
- CLEAR:
  - Entered on any edge with i_rst=1. While i_rst stays high, the counter is held at 1.
  - On each edge with i_rst=0, writes 0 to the register at counter, then increments counter.
  - After writing NREGS-1, moves to RUN.
  - i_ce_wr is ignored throughout CLEAR.
  - If i_ce_rd=1, read ports capture 0 and o_rs_illegal=0.
- RUN:
  - A write occurs when i_ce_wr=1, i_rd_addr!=0 and i_rd_addr<NREGS. Writes to x0 or to an out-of-range address are dropped silently.
- Read, when i_ce_rd=1 in RUN, for each port k with address A:
  - A==0: o_rs_data[k] <= 0.
  - A>=NREGS: o_rs_data[k] <= 0 and o_rs_illegal[k] <= 1.
  - Otherwise: o_rs_data[k] <= reg[A] and o_rs_illegal[k] <= 0.
- When i_ce_rd=0, o_rs_data and o_rs_illegal hold their values.
- Multiple ports may read the same address in one cycle; each returns the same value.
- Register x0 has no storage and always reads 0.

## Timing
- Values during reset and on the first edge after i_rst falls: o_rs_data=0, o_rs_illegal=0, o_busy=1.
- o_busy is high for exactly NREGS-1 edges after i_rst falls, then low.
  - NREGS=32: 31 cycles.
  - NREGS=16: 15 cycles.
- Read latency is one edge: the address presented with i_ce_rd at edge N appears on o_rs_data after edge N.
- Write to read-visible latency is one edge: a read captured at edge N+1 or later returns data written at edge N.
- Same-edge collision (write to A and read capture of A at one edge): behaviour is set by the bypass macro; see Configuration.
- Reset asserted mid-CLEAR restarts the counter at 1. Reset asserted in RUN returns to CLEAR and zeroes all registers again.
- i_rst takes priority over i_ce_rd and i_ce_wr on the same edge.

## Configuration
- ASRV32_REGFILE_BYPASS_EN defined: on a same-edge collision with a legal write to nonzero A, o_rs_data[k] captures i_rd_data (the new value).
- ASRV32_REGFILE_BYPASS_EN undefined: on a same-edge collision, o_rs_data[k] captures the old contents of reg[A].
- x0 and out-of-range addresses never bypass, in either configuration.

## Structure
- Shared package asrv32_pkg holds:
  - XLEN default.
  - REG_ADDR_W=5.
  - Legal NREGS values (RV32I_NREGS=32, RV32E_NREGS=16).
  - State enum rf_state_t {RF_CLEAR, RF_RUN}.
- One sub-module, asrv32_regfile_clr, holds the clear sequencer: state, counter, o_busy, and the clear write address/enable.
- The top level muxes the sequencer's write port against the user write port.
- Elaboration fails on an illegal NREGS or NRD.

## Test plan
- Reset clear (NREGS=32): set all registers to 0xFFFFFFFF, pulse i_rst, read x1..x31 after o_busy falls -> every read returns 0; o_busy is high for exactly 31 cycles.
- Basic write and read: write x5=0xDEADBEEF, next cycle read x5 on port0 and x0 on port1 -> port0=0xDEADBEEF, port1=0; writing x0=0x1234 then reading x0 -> 0.
- Collision: same edge writes x7=0xA5A5A5A5 (old 0x11111111) and reads x7 -> 0xA5A5A5A5 with ASRV32_REGFILE_BYPASS_EN, 0x11111111 without; the read on the following edge returns 0xA5A5A5A5 in both.
- RV32E range (NREGS=16): write x20=0x55, then read x20 -> data 0 with o_rs_illegal=1; reading x15 afterwards -> o_rs_illegal=0.
- Hold and multi-port (NRD=3): all three ports read x9=0x42 -> all return 0x42; drop i_ce_rd and change the addresses -> outputs unchanged.
- Reset mid-clear and writes during clear: assert i_rst 10 cycles into CLEAR -> o_busy stays high 31 cycles after the final release; i_ce_wr x3=0x99 during CLEAR -> x3 reads 0.
